tone_detector: RTL

- Receive-side counterpart of the button-driven tone generator.
- Monitors the 1-bit audio line (PWM carrier modulated by a square tone) and recovers the tone envelope.
- Measures the tone period and classifies it as one of the four notes (D/E/G/A) or none.
- Used for loopback self-test of the audio path and for the note indicator display.

---
 rtl/tone_detector.sv | 95 +++++++++
 1 files changed

// File: rtl/tone_detector.sv
// tone_detector: recovers the tone envelope from a PWM audio line, measures its
// period in prescaler ticks and classifies it as note D/E/G/A after confirmation.
module tone_detector #(
    parameter int TICK_DIV = 64,
    parameter int HOLD     = 300,
    parameter int TOL      = 16,
    parameter int CONFIRM  = 2,
    parameter int TIMEOUT  = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ain,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_change,
    output logic [11:0] period
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD + 1);

    logic [PW-1:0] pre;
    logic          tick, s1, ain_s, env, env_d, env_rise, armed, armed_n, capture, timeout;
    logic [HW-1:0] hold;
    logic [11:0]   cnt;
    logic [2:0]    cls, cand, cand_n, match, match_n, note_n;

    function automatic logic near(input logic [11:0] p, input logic [11:0] nom);
        near = (p >= nom ? p - nom : nom - p) <= 12'(TOL);
    endfunction

    assign tick     = pre == PW'(TICK_DIV - 1);
    assign env_rise = env & ~env_d;
    assign capture  = env_rise & armed;
    // A rise in the same cycle beats the timeout; the capture then sees the stale count.
    assign timeout  = tick && cnt == 12'(TIMEOUT - 1) && !env_rise;
    assign cls      = near(cnt, 12'd1330) ? 3'd1 : near(cnt, 12'd1186) ? 3'd2 :
                      near(cnt, 12'd996)  ? 3'd3 : near(cnt, 12'd888)  ? 3'd4 : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre         <= '0;
            s1          <= 1'b0;
            ain_s       <= 1'b0;
            hold        <= '0;
            env         <= 1'b0;
            env_d       <= 1'b0;
            cnt         <= '0;
            period      <= '0;
            note_change <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + PW'(1);
            s1          <= ain;
            ain_s       <= s1;
            hold        <= ain_s ? HW'(HOLD) : hold != '0 ? hold - HW'(1) : '0;
            env         <= hold != '0;
            env_d       <= env;
            cnt         <= env_rise ? '0 : tick && cnt != 12'hfff ? cnt + 12'd1 : cnt;
            period      <= capture ? cnt : period;
            note_change <= note_n != note;
        end
    end

    // confirmation FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note  <= '0;
            cand  <= '0;
            match <= '0;
            armed <= 1'b0;
        end else begin
            note  <= note_n;
            cand  <= cand_n;
            match <= match_n;
            armed <= armed_n;
        end
    end

    // confirmation FSM: next state
    always_comb begin
        armed_n = env_rise | (armed & ~timeout);
        cand_n  = timeout ? 3'd0 : capture ? cls : cand;
        match_n = timeout ? 3'd0 :
                  !capture ? match :
                  cls == 3'd0 ? 3'd0 :
                  cls != cand ? 3'd1 :
                  match == 3'(CONFIRM) ? match : match + 3'd1;
        note_n  = timeout ? 3'd0 :
                  capture && match_n == 3'(CONFIRM) && cand_n != note ? cand_n : note;
    end

    // confirmation FSM: outputs
    always_comb begin
        note_valid = note != 3'd0;
    end
endmodule
